// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-bus target with 128 KB RAM, UART rx/tx FIFOs, cycle counter and stop register
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic        tx_overflow
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);

    logic [7:0] ram [2**RAM_ADDR_W];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [RXW-1:0] rx_wp, rx_rp;
    logic [RXW:0] rx_cnt, rx_cnt_n;
    logic [TXW-1:0] tx_wp, tx_rp;
    logic [TXW:0] tx_cnt, tx_cnt_n;
    logic [31:0] cnt;
    logic [23:0] shadow;
    logic term_pend;
    logic sel_ram, sel_io, io_rd, io_wr, off0, off4;
    logic rx_full, rx_empty, rx_pop, rx_push;
    logic tx_full, tx_pop, tx_room, data_wr, halt_wr, term_req, tx_push, halted_n;
    logic [7:0] tx_din, io_byte, rd_byte;
    logic unused_hi;

    assign unused_hi = ^mem_a[31:18];
    assign rx_ready = !rx_full;
    assign tx_valid = tx_cnt != '0;
    assign tx_data = tx_valid ? tx_mem[tx_rp] : 8'h00;

    // Decode, FIFO handshakes and read mux; once halted, I/O writes are ignored so a frozen CPU
    // holding a write cannot queue more bytes or a second terminator. A full FIFO still accepts
    // a push in a cycle that also pops.
    always_comb begin
        sel_ram = !mem_a[17];
        sel_io = &mem_a[17:16];
        io_rd = sel_io && !mem_wr;
        io_wr = sel_io && mem_wr && !halted;
        off0 = mem_a[3:0] == 4'h0;
        off4 = mem_a[3:0] == 4'h4;
        rx_empty = rx_cnt == '0;
        rx_full = rx_cnt == (RXW+1)'(RX_DEPTH);
        rx_pop = io_rd && off0 && rdy_out && !rx_empty;
        rx_push = rx_valid && (!rx_full || rx_pop);
        rx_cnt_n = rx_cnt + {{RXW{1'b0}}, rx_push} - {{RXW{1'b0}}, rx_pop};
        tx_full = tx_cnt == (TXW+1)'(TX_DEPTH);
        tx_pop = tx_valid && tx_ready;
        tx_room = !tx_full || tx_pop;
        data_wr = io_wr && off0 && mem_dout != 8'h00;
        halt_wr = io_wr && off4;
        term_req = halt_wr || term_pend;
        tx_push = tx_room && (term_req || data_wr);
        tx_din = term_req ? 8'h00 : mem_dout;
        tx_cnt_n = tx_cnt + {{TXW{1'b0}}, tx_push} - {{TXW{1'b0}}, tx_pop};
        halted_n = halted || halt_wr;
        io_byte = off0 ? (rx_empty ? 8'h00 : rx_mem[rx_rp]) :
                  off4 ? cnt[7:0] :
                  mem_a[3:0] == 4'h5 ? shadow[7:0] :
                  mem_a[3:0] == 4'h6 ? shadow[15:8] :
                  mem_a[3:0] == 4'h7 ? shadow[23:16] : 8'h00;
        rd_byte = sel_ram ? ram[mem_a[RAM_ADDR_W-1:0]] : sel_io ? io_byte : 8'h00;
    end

    // Byte RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (mem_wr && sel_ram && !rst_in) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    end

    // FIFO storage arrays
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
        if (tx_push) tx_mem[tx_wp] <= tx_din;
    end

    // Pointers, counters, status flags, read data and backpressure
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
            rdy_out <= 1'b1;
            halted <= 1'b0;
            tx_overflow <= 1'b0;
            term_pend <= 1'b0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_cnt <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
            tx_cnt <= '0;
            cnt <= 32'd0;
            shadow <= 24'd0;
        end else begin
            if (!mem_wr) mem_din <= rd_byte;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt_n;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt_n;
            cnt <= cnt + 32'd1;
            if (io_rd && off4 && rdy_out) shadow <= cnt[31:8];
            halted <= halted_n;
            term_pend <= term_req && !tx_room;
            if (data_wr && !tx_room) tx_overflow <= 1'b1;
            rdy_out <= !halted_n && tx_cnt_n < (TXW+1)'(TX_DEPTH - 1);
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_mem_io_responder;
    localparam int RXD = 8;
    localparam int TXD = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    logic [31:0] mem_a;
    logic [7:0] mem_dout;
    logic mem_wr;
    logic [7:0] mem_din;
    logic rdy_out;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic halted;
    logic tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .rdy_out(rdy_out), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted(halted), .tx_overflow(tx_overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0] d;
        logic wr;
        logic rxv;
        logic [7:0] rxd;
        logic [7:0] exp_din;
    } vec_t;

    int total = 0;
    int bad = 0;
    vec_t vt[13];
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_ram [int];
    logic [7:0] m_din;
    bit m_known, m_rdy, m_halt, m_term, m_ovf;
    logic [31:0] m_cnt;
    logic [23:0] m_shadow;
    logic [7:0] wseq[10];
    logic [31:0] ram_addrs[8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the pre-edge inputs and model state
    task automatic model_step();
        logic [17:0] a;
        logic [3:0] o;
        bit io, rxpop, txpop, room, rx_ok;
        a = mem_a[17:0];
        o = a[3:0];
        io = a[17:16] == 2'b11;
        if (rst_in) begin
            rxq.delete(); txq.delete();
            m_din = 8'h00; m_known = 1; m_halt = 0; m_term = 0; m_ovf = 0;
            m_cnt = 0; m_shadow = 0; m_rdy = 1;
            return;
        end
        rxpop = 0;
        txpop = txq.size() > 0 && tx_ready;
        room = txq.size() < TXD || txpop;
        rx_ok = rxq.size() < RXD;
        if (!mem_wr) begin
            m_known = 1;
            if (!a[17]) begin
                if (m_ram.exists(int'(a[16:0]))) m_din = m_ram[int'(a[16:0])];
                else m_known = 0;
            end else if (!io) m_din = 8'h00;
            else case (o)
                4'h0: begin
                    m_din = rxq.size() > 0 ? rxq[0] : 8'h00;
                    rxpop = m_rdy && rxq.size() > 0;
                end
                4'h4: begin
                    m_din = m_cnt[7:0];
                    if (m_rdy) m_shadow = m_cnt[31:8];
                end
                4'h5: m_din = m_shadow[7:0];
                4'h6: m_din = m_shadow[15:8];
                4'h7: m_din = m_shadow[23:16];
                default: m_din = 8'h00;
            endcase
        end
        if (txpop) void'(txq.pop_front());
        if (mem_wr && !a[17]) m_ram[int'(a[16:0])] = mem_dout;
        if (mem_wr && io && !m_halt && o == 4'h0 && mem_dout != 8'h00) begin
            if (room) txq.push_back(mem_dout);
            else m_ovf = 1;
        end
        if (mem_wr && io && !m_halt && o == 4'h4) begin
            m_halt = 1;
            m_term = 1;
        end
        if (m_term && room) begin
            txq.push_back(8'h00);
            m_term = 0;
        end
        if (rxpop) void'(rxq.pop_front());
        if (rx_valid && (rx_ok || rxpop)) rxq.push_back(rx_data);
        m_cnt++;
        m_rdy = !m_halt && txq.size() < TXD - 1;
    endtask

    task automatic check_all();
        if (m_known) chk("mem_din", {24'd0, mem_din}, {24'd0, m_din});
        chk("rdy_out", rdy_out, m_rdy);
        chk("halted", halted, m_halt);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("tx_valid", tx_valid, txq.size() > 0);
        chk("tx_data", tx_data, txq.size() > 0 ? txq[0] : 8'h00);
        chk("rx_ready", rx_ready, rxq.size() < RXD);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        check_all();
    endtask

    task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic w);
        mem_a = a;
        mem_dout = d;
        mem_wr = w;
    endtask

    task automatic do_reset();
        rst_in = 1;
        cyc();
        cyc();
        rst_in = 0;
    endtask

    task automatic drain();
        got.delete();
        tx_ready = 1;
        for (int k = 0; k < 40; k++) begin
            if (!tx_valid) break;
            got.push_back(tx_data);
            cyc();
        end
    endtask

    task automatic check_drain(input string n);
        chk({n, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", n, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'h00010, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5};
        vt[2]  = '{32'h1FFFF, 8'h3C, 1'b1, 1'b0, 8'h00, 8'hA5};
        vt[3]  = '{32'h1FFFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C};
        vt[4]  = '{32'h20000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[5]  = '{32'h20000, 8'h77, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[6]  = '{32'h20000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[7]  = '{32'h30008, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[8]  = '{32'h00010, 8'h00, 1'b0, 1'b1, 8'h41, 8'hA5};
        vt[9]  = '{32'h00010, 8'h00, 1'b0, 1'b1, 8'h42, 8'hA5};
        vt[10] = '{32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h41};
        vt[11] = '{32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h42};
        vt[12] = '{32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        wseq = '{8'h61, 8'h00, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
        ram_addrs = '{32'h0, 32'h1, 32'h10, 32'h1234, 32'hFFFF, 32'h10000, 32'h1FFFE, 32'h1FFFF};
        drive(32'h0, 8'h00, 1'b0);
        rx_valid = 0;
        rx_data = 0;
        tx_ready = 0;
        do_reset();
        chk("reset_din", {24'd0, mem_din}, 32'h0);
        chk("reset_rdy", rdy_out, 1);
        chk("reset_txv", tx_valid, 0);
        chk("reset_rxr", rx_ready, 1);

        // RAM, unmapped window and rx pops from a table
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].a, vt[i].d, vt[i].wr);
            rx_valid = vt[i].rxv;
            rx_data = vt[i].rxd;
            cyc();
            chk($sformatf("vec%0d", i), {24'd0, mem_din}, {24'd0, vt[i].exp_din});
        end
        rx_valid = 0;

        // tx fill: zero byte skipped, rdy falls at 7, 8th accepted, 9th dropped
        begin
            int np;
            np = 0;
            tx_ready = 0;
            for (int i = 0; i < 10; i++) begin
                drive(32'h30000, wseq[i], 1'b1);
                cyc();
                if (wseq[i] != 8'h00 && np < 8) np++;
                chk($sformatf("tx_rdy%0d", i), rdy_out, np < 7);
                chk($sformatf("tx_ovf%0d", i), tx_overflow, i == 9);
            end
        end
        drive(32'h10, 8'h00, 1'b0);
        rx_valid = 1;
        rx_data = 8'h51;
        cyc();
        rx_valid = 0;
        drive(32'h30000, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("hold_pop%0d", i), {24'd0, mem_din}, 32'h51);
        end
        drive(32'h10, 8'h00, 1'b0);
        drain();
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        check_drain("tx_order");
        drive(32'h30000, 8'h00, 1'b0);
        cyc();
        chk("rx_after_hold", {24'd0, mem_din}, 32'h51);
        cyc();
        chk("rx_empty_after", {24'd0, mem_din}, 32'h0);

        // coherent counter read at 0x1FF
        do_reset();
        drive(32'h10, 8'h00, 1'b0);
        for (int k = 0; k < 2000 && m_cnt != 32'h1FF; k++) cyc();
        drive(32'h30004, 8'h00, 1'b0); cyc(); chk("cnt_b0", {24'd0, mem_din}, 32'hFF);
        drive(32'h30005, 8'h00, 1'b0); cyc(); chk("cnt_b1", {24'd0, mem_din}, 32'h01);
        drive(32'h30006, 8'h00, 1'b0); cyc(); chk("cnt_b2", {24'd0, mem_din}, 32'h00);
        drive(32'h30007, 8'h00, 1'b0); cyc(); chk("cnt_b3", {24'd0, mem_din}, 32'h00);

        // halt with tx full: terminator held, then appended last
        tx_ready = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h30000, 8'(8'h71 + i), 1'b1);
            cyc();
        end
        drive(32'h30004, 8'h99, 1'b1);
        cyc();
        chk("halt_set", halted, 1);
        chk("halt_rdy0", rdy_out, 0);
        chk("halt_no_ovf", tx_overflow, 0);
        drive(32'h10, 8'h00, 1'b0);
        drain();
        exp_q = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h00};
        check_drain("halt_drain");
        chk("halt_rdy_stays", rdy_out, 0);
        cyc();
        chk("pre_rst_din", {24'd0, mem_din}, 32'hA5);
        rst_in = 1;
        cyc();
        chk("rst_din", {24'd0, mem_din}, 32'h0);
        chk("rst_halted", halted, 0);
        chk("rst_rdy", rdy_out, 1);
        chk("rst_txv", tx_valid, 0);
        rst_in = 0;
        cyc();

        // rx full with simultaneous push and pop
        tx_ready = 0;
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1;
            rx_data = 8'(8'h80 + i);
            cyc();
        end
        chk("rx_full", rx_ready, 0);
        rx_data = 8'h88;
        drive(32'h30000, 8'h00, 1'b0);
        cyc();
        chk("rx_pp_din", {24'd0, mem_din}, 32'h80);
        chk("rx_pp_ready", rx_ready, 0);
        rx_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("rx_order%0d", i), {24'd0, mem_din}, 32'(8'h80 + i));
        end
        cyc();
        chk("rx_drained", {24'd0, mem_din}, 32'h0);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [3:0] off;
            rst_in = m_halt ? ($urandom % 40 == 0) : ($urandom % 400 == 0);
            r = $urandom % 10;
            off = 4'($urandom % 9);
            if (r < 4) begin
                mem_a = ram_addrs[$urandom % 8] | {$urandom, 18'd0};
                mem_wr = ($urandom % 3 == 0);
            end else if (r == 4) begin
                mem_a = {14'($urandom), 2'b10, 16'($urandom)};
                mem_wr = $urandom % 2;
            end else begin
                mem_a = {14'($urandom), 2'b11, 12'($urandom), off};
                mem_wr = off == 4'h4 ? ($urandom % 60 == 0) : ($urandom % 2 == 1);
            end
            mem_dout = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            rx_valid = $urandom % 2;
            rx_data = 8'($urandom);
            tx_ready = ($urandom % 3 == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Target-side responder for the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din).
- Holds the 128 KB byte RAM and decodes the I/O window where mem_a[17:16]==2'b11: UART rx/tx byte queues, a free-running cycle counter and the program-stop register.
- Delivers read data one cycle after the address, so the CPU sees a 2-cycle read and a 1-cycle write.
- Drives the CPU's rdy_in to apply backpressure and to freeze the core after stop.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB).
RX_DEPTH, 8, rx FIFO entries (power of two).
TX_DEPTH, 8, tx FIFO entries (power of two, >=4).

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset
mem_a  in  32  byte address from CPU; only [17:0] decoded
mem_dout  in  8  write data from CPU
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data to CPU
rdy_out  out  1  to CPU rdy_in; CPU frozen when low
rx_data  in  8  received byte from UART
rx_valid  in  1  rx_data valid
rx_ready  out  1  rx FIFO can accept
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx FIFO non-empty
tx_ready  in  1  transmitter accepts tx_data
halted  out  1  program-stop seen (sticky)
tx_overflow  out  1  sticky: a tx write was dropped

Behaviour:
- Single clock domain clk_in. rst_in is synchronous and active-high.
- Reset values: mem_din=0, rdy_out=1, halted=0, tx_overflow=0, both FIFOs empty (rx_ready=1, tx_valid=0, tx_data=0), counter=0, shadow=0. RAM contents are not reset.
- Decode on mem_a[17:16]:
  - 00/01: RAM.
  - 10: unmapped; reads return 0x00, writes are dropped.
  - 11: I/O; only mem_a[3:0] is decoded.
- Read (mem_wr=0): at a clock edge, mem_din <= selected byte, giving 1-cycle latency. mem_din updates every read cycle regardless of rdy_out. In write cycles mem_din holds its value.
- RAM write (mem_wr=1): the byte is written at the edge. A read of the same address in the next cycle returns the new byte.
- I/O read side effects (pops, snapshots) occur only when rdy_out=1, so a paused CPU holding its address does not repeat them.
- 0x30000 read:
  - rx FIFO non-empty: return head and pop.
  - rx FIFO empty: return 0x00, no pop.
- 0x30004 read: return counter[7:0] and snapshot counter[31:8] into a shadow register.
- 0x30005 / 0x30006 / 0x30007 reads: return shadow bytes 0 / 1 / 2. This gives a coherent little-endian 32-bit read.
- All other I/O reads return 0x00.
- Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF -> 0. It keeps counting while halted.
- 0x30000 write:
  - data 0x00: ignored.
  - data nonzero, tx FIFO not full: push.
  - data nonzero, tx FIFO full: drop and set tx_overflow.
- 0x30004 write: set halted. 0x00 is pushed to tx as the terminator, using the reserved slot. If the FIFO is full, the push is held pending and made on the first cycle with space. Data value is ignored.
- All other I/O writes are ignored.
- rdy_out (registered) = !halted && (tx_count < TX_DEPTH-1). One slot stays reserved for the write the CPU issues in the cycle rdy falls. After halt, rdy_out stays 0 until reset.
- tx FIFO: tx_valid = non-empty, tx_data = head, pop on tx_valid && tx_ready.
- rx FIFO: rx_ready = !full, push on rx_valid && rx_ready.
- Both FIFOs support simultaneous push and pop, including at full and at empty. Pointers wrap modulo depth.
- Reset mid-operation flushes both FIFOs and any pending terminator, and clears halted. An in-flight read yields mem_din=0 on the cycle after reset.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 one cycle after address. Read 0x1FFFF after writing 0x3C there -> 0x3C. Read 0x20000 -> 0x00.
- Push rx bytes 0x41, 0x42; read 0x30000 three times -> 0x41, 0x42, 0x00. rx FIFO empty after second pop. Hold address 0x30000 with rdy_out=0 -> no extra pop.
- Hold tx_ready=0; write 0x30000 with 0x61, 0x00, 0x62... -> 0x00 not queued, rdy_out falls when count reaches 7. Eighth byte accepted; ninth write dropped and tx_overflow=1. Release tx_ready -> bytes emitted in order.
- Counter at 0x000001FF: read 0x30004..0x30007 in consecutive cycles -> 0xFF, 0x01, 0x00, 0x00 despite the counter advancing.
- Write 0x30004 with tx FIFO full -> halted=1, rdy_out=0. After drain, final tx byte is 0x00. Assert rst_in -> halted=0, rdy_out=1, tx_valid=0.
- Simultaneous rx push and 0x30000 pop with rx FIFO full -> count unchanged, order preserved, rx_ready stays 0.
